// File: rtl/hash_stream_pkg.sv
// Shared types and constants for the hash message streamer and its byte FIFO.
package hash_stream_pkg;

    localparam int DIGEST_W  = 32;
    localparam int BYTE_W    = 8;
    localparam int COUNTER_W = 64;

    localparam int DEFAULT_DEPTH          = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/stream_byte_fifo.sv
// Single-clock show-ahead byte FIFO; DEPTH must be a power of two so the
// pointers wrap naturally and count needs one extra bit to tell full from empty.
module stream_byte_fifo
    import hash_stream_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [BYTE_W-1:0]           din,
    input  logic                        pop,
    output logic [BYTE_W-1:0]           dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // NOTE: storage is never reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/hash_msg_streamer.sv
// Buffers host bytes, streams them to the DES-box hash core and returns the digest.
// Optional WAIT timeout is enabled by defining HASH_STREAM_TIMEOUT_EN.
module hash_msg_streamer
    import hash_stream_pkg::*;
#(
    parameter int DEPTH          = DEFAULT_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_byte,
    output logic                 in_ready,
    input  logic                 start,
    output logic                 busy,
    output logic                 M_valid,
    output logic [BYTE_W-1:0]    message,
    output logic [COUNTER_W-1:0] counter,
    input  logic                 hash_ready,
    input  logic [DIGEST_W-1:0]  digest_in,
    output logic [DIGEST_W-1:0]  digest_out,
    output logic                 digest_valid,
    input  logic                 digest_ready,
    output logic                 timeout_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e              state_q;
    state_e              state_d;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       len_q;
    logic [BYTE_W-1:0]   fifo_dout;
    logic [DIGEST_W-1:0] digest_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                start_ok;
    logic                capture;
    logic                wait_armed;
    logic                timeout_hit;

    assign in_ready = (state_q == IDLE) && !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == SEND);
    assign start_ok = start && (state_q == IDLE);

    stream_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in_byte),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The first WAIT cycle is never armed: the core may still show the previous digest.
`ifdef HASH_STREAM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt_q;
    logic          err_q;

    assign wait_armed  = (wait_cnt_q != '0);
    assign timeout_hit = (state_q == WAIT) && !(wait_armed && hash_ready)
                         && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + TW'(1) : '0;
            if (start_ok)         err_q <= 1'b0;
            else if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    logic armed_q;
    logic unused_cfg;

    assign wait_armed  = armed_q;
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = (TIMEOUT_CYCLES > 0);

    always_ff @(posedge clk) begin
        if (!rst_n) armed_q <= 1'b0;
        else        armed_q <= (state_q == WAIT);
    end
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = SEND;
            SEND: if (fifo_count <= CW'(1)) state_d = WAIT;
            WAIT: begin
                if (wait_armed && hash_ready) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            DONE: if (digest_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            digest_q <= '0;
        end else begin
            state_q <= state_d;
            // A byte pushed alongside start is already part of the message.
            if (start_ok) len_q    <= fifo_count + CW'(push);
            if (capture)  digest_q <= digest_in;
        end
    end

    assign busy         = (state_q != IDLE);
    assign M_valid      = (state_q == SEND);
    assign message      = (state_q == SEND && !fifo_empty) ? fifo_dout : '0;
    assign counter      = COUNTER_W'((state_q == IDLE) ? fifo_count : len_q);
    assign digest_out   = digest_q;
    assign digest_valid = (state_q == DONE);

endmodule

// File: tb/tb_hash_msg_streamer.sv
// Self-checking bench: table vectors, corner sequences and random traffic
// against a queue-based model with a scripted stand-in for the hash core.
module tb_hash_msg_streamer;

    localparam int DEPTH   = 128;
    localparam int TIMEOUT = 20;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        string       text;
        logic [31:0] digest;
        int          lat;
        bit          stale;
        bit          fused;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_ready;
    logic        start = 1'b0;
    logic        busy;
    logic        M_valid;
    logic [7:0]  message;
    logic [63:0] counter;
    logic        hash_ready = 1'b0;
    logic [31:0] digest_in = '0;
    logic [31:0] digest_out;
    logic        digest_valid;
    logic        digest_ready = 1'b0;
    logic        timeout_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    byte_q_t     model_buf;
    logic [31:0] last_digest = '0;
    vec_t        vecs[5];

    hash_msg_streamer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .start        (start),
        .busy         (busy),
        .M_valid      (M_valid),
        .message      (message),
        .counter      (counter),
        .hash_ready   (hash_ready),
        .digest_in    (digest_in),
        .digest_out   (digest_out),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time exhausted, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic byte_q_t str2q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // FNV-1a stands in for the core's digest on random messages.
    function automatic logic [31:0] fnv(input byte_q_t q);
        logic [31:0] h = 32'h811c9dc5;
        foreach (q[i]) h = (h ^ {24'h0, q[i]}) * 32'h01000193;
        return h;
    endfunction

    // Offers bytes while IDLE; the model accepts only while the buffer has room.
    task automatic write_bytes(input byte_q_t bytes);
        foreach (bytes[i]) begin
            check("in_ready", in_ready, (model_buf.size() < DEPTH));
            check("counter_idle", counter, model_buf.size());
            in_valid = 1'b1;
            in_byte  = bytes[i];
            if (model_buf.size() < DEPTH) model_buf.push_back(bytes[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start(input bit with_byte, input logic [7:0] b);
        check("busy_before_start", busy, 0);
        start = 1'b1;
        if (with_byte) begin
            in_valid = 1'b1;
            in_byte  = b;
            if (model_buf.size() < DEPTH) model_buf.push_back(b);
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Checks the SEND beats against the model buffer; leaves us in the first WAIT cycle.
    task automatic check_send(output int n);
        byte_q_t exp = model_buf;
        int nb;
        n  = exp.size();
        nb = (n == 0) ? 1 : n;
        model_buf.delete();
        for (int i = 0; i < nb; i++) begin
            check("M_valid_send", M_valid, 1);
            check("message", message, (n == 0) ? 8'h00 : exp[i]);
            check("counter_send", counter, n);
            check("in_ready_send", in_ready, 0);
            if (i == 0) begin
                in_valid = 1'b1;
                in_byte  = 8'hEE;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("M_valid_wait", M_valid, 0);
        check("busy_wait", busy, 1);
    endtask

    task automatic finish_txn(input logic [31:0] dig, input int lat, input bit stale);
        int n;
        check_send(n);
        if (stale) begin
            hash_ready = 1'b1;
            digest_in  = ~dig;
        end
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        hash_ready = 1'b0;
        for (int j = 0; j < lat; j++) begin
            check("digest_valid_early", digest_valid, 0);
            @(negedge clk);
        end
        check("digest_valid_pre", digest_valid, 0);
        check("counter_wait", counter, n);
        hash_ready = 1'b1;
        digest_in  = dig;
        @(negedge clk);
        hash_ready = 1'b0;
        digest_in  = $urandom;
        last_digest = dig;
        check("digest_valid", digest_valid, 1);
        check("digest_out", digest_out, dig);
        for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
            @(negedge clk);
            check("digest_valid_hold", digest_valid, 1);
        end
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        check("digest_valid_clr", digest_valid, 0);
        check("busy_idle", busy, 0);
        check("counter_idle_after", counter, 0);
        check("in_ready_idle", in_ready, 1);
        check("digest_out_hold", digest_out, dig);
        check("timeout_err", timeout_err, 0);
    endtask

    task automatic run_txn(input byte_q_t msg, input logic [31:0] dig, input int lat,
                           input bit stale, input bit fused);
        if (fused && msg.size() > 0) begin
            logic [7:0] last = msg[msg.size()-1];
            msg.pop_back();
            write_bytes(msg);
            do_start(1'b1, last);
        end else begin
            write_bytes(msg);
            do_start(1'b0, 8'h00);
        end
        finish_txn(dig, lat, stale);
    endtask

    initial begin
        vecs[0] = '{"", 32'h83656fd2, 2, 1'b0, 1'b0};
        vecs[1] = '{"AB", 32'h83656fd4, 3, 1'b1, 1'b0};
        vecs[2] = '{"AB", 32'h83656fd4, 0, 1'b1, 1'b0};
        vecs[3] = '{"HARDWARE_AND_EMBEDDED_SECURITY_FULL_HASH_DES_BOX_PROJECT_bigliazzi_venturini_2022",
                    32'hc0872334, 1, 1'b0, 1'b0};
        vecs[4] = '{"XYZ", 32'h12345678, 0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_M_valid", M_valid, 0);
        check("rst_message", message, 0);
        check("rst_counter", counter, 0);
        check("rst_digest_out", digest_out, 0);
        check("rst_digest_valid", digest_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) run_txn(str2q(vecs[v].text), vecs[v].digest, vecs[v].lat,
                                   vecs[v].stale, vecs[v].fused);

        // Full buffer: the byte offered past DEPTH is refused.
        begin
            byte_q_t q;
            for (int i = 0; i <= DEPTH; i++) q.push_back(8'($urandom));
            write_bytes(q);
            check("full_in_ready", in_ready, 0);
            check("full_counter", counter, DEPTH);
            do_start(1'b0, 8'h00);
            finish_txn(fnv(q[0:DEPTH-1]), 1, 1'b0);
        end

        // Reset during SEND discards buffer and digest.
        write_bytes(str2q("HELLO"));
        do_start(1'b0, 8'h00);
        check("rst_send_mv", M_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_buf.delete();
        check("midrst_M_valid", M_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_counter", counter, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_digest_out", digest_out, 0);
        last_digest = '0;
        run_txn(str2q("Q"), 32'hA5A5_0001, 1, 1'b0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            byte_q_t q;
            int len = $urandom_range(0, 40);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            run_txn(q, fnv(q), $urandom_range(0, 4), 1'($urandom), 1'($urandom));
        end

`ifdef HASH_STREAM_TIMEOUT_EN
        begin
            int n;
            write_bytes(str2q("TMO"));
            do_start(1'b0, 8'h00);
            check_send(n);
            for (int k = 0; k < TIMEOUT; k++) begin
                check("tmo_err_low", timeout_err, 0);
                check("tmo_busy", busy, 1);
                @(negedge clk);
            end
            check("tmo_err_set", timeout_err, 1);
            check("tmo_busy_idle", busy, 0);
            check("tmo_digest_valid", digest_valid, 0);
            check("tmo_counter", counter, 0);
            check("tmo_digest_out", digest_out, last_digest);
            do_start(1'b0, 8'h00);
            check("tmo_err_clr", timeout_err, 0);
            finish_txn(32'h0BAD_F00D, 0, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hash_msg_streamer.md
Name: hash_msg_streamer

Overview:
Front-end transmitter for the DES-box hash core.
- Collects message bytes from a host-side valid/ready port into a local buffer.
- On start, drives the core's M_valid/message/counter protocol.
- Waits for hash_ready, captures the 32-bit digest and hands it back through a valid/ready result port.
- Sits between the system bus adapter and full_hash_des_box.

Parameters:
DEPTH, 16, byte buffer capacity; power of two, 2..256.
TIMEOUT_CYCLES, 64, maximum wait for hash_ready (used only with the optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
in_valid  in  1  host byte valid
in_byte  in  8  host message byte
in_ready  out  1  buffer can accept a byte (state IDLE and not full)
start  in  1  one-cycle pulse: hash the buffered bytes
busy  out  1  high from accepted start until the digest is consumed
M_valid  out  1  to core: byte/length valid
message  out  8  to core: current byte
counter  out  64  to core: message length in bytes
hash_ready  in  1  from core: digest valid
digest_in  in  32  from core: digest
digest_out  out  32  captured digest
digest_valid  out  1  captured digest available
digest_ready  in  1  consumer accepts the digest
timeout_err  out  1  sticky error flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset values: in_ready=1, busy=0, M_valid=0, message=0, counter=0, digest_out=0, digest_valid=0, timeout_err=0. Buffer is emptied; state=IDLE.
- Reset taking effect mid-operation aborts everything immediately. Buffered bytes and the captured digest are discarded.
- Write side: a byte is stored when in_valid && in_ready. The count register is zero-extended into counter.
- in_ready=0 when the buffer is full or state != IDLE. In those cases in_valid is ignored and the byte is not stored.
- start is honoured only in IDLE and is ignored elsewhere.
- If start and in_valid arrive in the same cycle, the byte is stored first and included in the length.
- States: IDLE -> SEND -> WAIT -> DONE -> IDLE.
- IDLE + start with count N>0 -> SEND.
  - counter=N stays stable through SEND.
  - M_valid=1 for exactly N consecutive cycles, bytes in write order (FIFO), one byte per cycle, no gaps.
- IDLE + start with N=0 -> SEND for a single cycle with M_valid=1, counter=0, message=0.
- SEND -> WAIT after the last beat; M_valid=0 in WAIT.
- WAIT ignores hash_ready in its first cycle, since the core may still show the previous result.
- From the second WAIT cycle, hash_ready=1 -> capture digest_in into digest_out and go to DONE.
- DONE: digest_valid=1. digest_ready && digest_valid -> digest_valid=0, go to IDLE, buffer empty, counter=0.
- digest_out holds its value until the next capture.
- busy = (state != IDLE).
- Latency from start to digest_valid: N + 1 + (core latency) cycles, plus 1 capture cycle (for N=0, count N as 1).
- Buffer pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1, so "full" is distinguished from "empty".

Optional Feature:
HASH_STREAM_TIMEOUT_EN.
- Defined: a WAIT-state counter starts at 0 on WAIT entry.
  - If it reaches TIMEOUT_CYCLES with no hash_ready, set timeout_err=1, leave digest_out unchanged, and go to IDLE with the buffer emptied (no digest_valid).
  - timeout_err clears only on reset or on the next accepted start.
- Undefined: no counter is present, timeout_err is tied 0, and WAIT lasts until hash_ready.

Decomposition:
- Package hash_stream_pkg holds:
  - state enum (IDLE, SEND, WAIT, DONE)
  - DIGEST_W=32, BYTE_W=8, COUNTER_W=64
  - default DEPTH/TIMEOUT_CYCLES constants
- One sub-module, stream_byte_fifo:
  - synchronous single-clock FIFO, parameterised DEPTH
  - push/pop/full/empty/count
  - same clk/rst_n convention

Test Plan:
1. Empty message:
   - Stimulus: start with no bytes, hashed by the real core.
   - Required: one M_valid cycle with counter=0; digest_out=32'h83656fd2; digest_valid held until digest_ready.
2. "AB":
   - Stimulus: write 'A','B', then start.
   - Required: M_valid high 2 cycles, message 8'h41 then 8'h42, counter=2; digest_out=32'h83656fd4. Repeat the run and get an identical digest.
3. Long message:
   - Stimulus: DEPTH=128; write "HARDWARE_AND_EMBEDDED_SECURITY_FULL_HASH_DES_BOX_PROJECT_bigliazzi_venturini_2022" (81 bytes).
   - Required: counter=81, 81 gapless beats, digest_out=32'hc0872334.
4. Full buffer:
   - Stimulus: DEPTH=16; offer 17 bytes, then start.
   - Required: in_ready drops after byte 16; byte 17 is not stored; counter=16.
5. Start and in_valid in the same cycle / reset mid-SEND:
   - Same cycle: the byte is included (counter increases by 1).
   - rst_n=0 during SEND: the next cycle shows M_valid=0, busy=0, buffer empty.
6. Timeout (macro defined):
   - Stimulus: stubbed core never raises hash_ready.
   - Required: timeout_err=1 exactly TIMEOUT_CYCLES after WAIT entry, state IDLE, no digest_valid; next start clears timeout_err.
